mips_mem_arbiter: RTL

Single-port memory arbiter for the pipelined MIPS core. It shares the unified 1024×32 instruction/data memory between the fetch stage (IF requester) and the memory stage (DM requester). It runs one transaction at a time using a req/gnt/rvalid handshake. Data accesses have priority; an optional anti-starvation counter guarantees forward progress for fetch.

---
 rtl/mips_mem_arbiter_if.sv | 45 ++++
 rtl/mips_mem_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter_if.sv
// Request/response and memory bus between the MIPS fetch/data stages, the arbiter and the shared memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mips_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter sharing one memory between fetch (IF) and data (DM) requesters.
// Optional fetch anti-starvation counter enabled by defining MEM_ARB_STARVE_EN.
module mips_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    mips_mem_arbiter_if.slave    bus,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam int LAT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);

    // Elaboration-time sanity check on configuration.
    if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_param
        $error("mips_mem_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
    end

    state_t             state_reg;
    logic               owner_dm_reg;
    logic               drop_reg;
    logic               busy_reg;
    logic [LAT_W-1:0]   lat_cnt_reg;
    logic               mem_en_reg;
    logic               mem_we_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [DATA_W-1:0]  mem_wdata_reg;
    logic               if_rvalid_reg;
    logic [DATA_W-1:0]  if_rdata_reg;
    logic               dm_rvalid_reg;
    logic [DATA_W-1:0]  dm_rdata_reg;

    logic if_wins;
    logic grant_ok;
    logic if_gnt_int;
    logic dm_gnt_int;

`ifdef MEM_ARB_STARVE_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_reg;

    // Counts DM grants taken while fetch was waiting; saturates so IF keeps winning until served.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else if (if_gnt_int) begin
            starve_cnt_reg <= '0;
        end else if (dm_gnt_int && bus.if_req && (starve_cnt_reg != STARVE_LIM)) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end

    assign if_wins = bus.if_req && (!bus.dm_req || (starve_cnt_reg == STARVE_LIM));
`else
    assign if_wins = bus.if_req && !bus.dm_req;
`endif

    // Grants are combinational but forced low while reset is asserted.
    assign grant_ok   = rst_n && (state_reg == IDLE);
    assign if_gnt_int = grant_ok && if_wins;
    assign dm_gnt_int = grant_ok && bus.dm_req && !if_wins;

    assign bus.if_gnt    = if_gnt_int;
    assign bus.dm_gnt    = dm_gnt_int;
    assign bus.if_rvalid = if_rvalid_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.dm_rvalid = dm_rvalid_reg;
    assign bus.dm_rdata  = dm_rdata_reg;
    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign busy          = busy_reg;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_dm_reg  <= 1'b0;
            drop_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            lat_cnt_reg   <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_rvalid_reg <= 1'b0;
            if_rdata_reg  <= '0;
            dm_rvalid_reg <= 1'b0;
            dm_rdata_reg  <= '0;
        end else begin
            if_rvalid_reg <= 1'b0;
            dm_rvalid_reg <= 1'b0;

            // A flush only matters while a fetch owns the memory.
            if (state_reg == IDLE) begin
                drop_reg <= 1'b0;
            end else if (!owner_dm_reg && bus.if_flush) begin
                drop_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (if_gnt_int || dm_gnt_int) begin
                        state_reg     <= ACCESS;
                        busy_reg      <= 1'b1;
                        owner_dm_reg  <= dm_gnt_int;
                        mem_en_reg    <= 1'b1;
                        mem_we_reg    <= dm_gnt_int && bus.dm_we;
                        mem_addr_reg  <= dm_gnt_int ? bus.dm_addr : bus.if_addr;
                        mem_wdata_reg <= dm_gnt_int ? bus.dm_wdata : '0;
                    end
                end
                ACCESS: begin
                    mem_en_reg <= 1'b0;
                    mem_we_reg <= 1'b0;
                    if (mem_we_reg) begin
                        state_reg     <= RESP;
                        dm_rvalid_reg <= 1'b1;
                        dm_rdata_reg  <= '0;
                    end else begin
                        state_reg   <= WAIT;
                        lat_cnt_reg <= LAT_W'(MEM_LAT - 1);
                    end
                end
                WAIT: begin
                    if (lat_cnt_reg == '0) begin
                        state_reg <= RESP;
                        if (owner_dm_reg) begin
                            dm_rvalid_reg <= 1'b1;
                            dm_rdata_reg  <= bus.mem_rdata;
                        end else if (!(drop_reg || bus.if_flush)) begin
                            if_rvalid_reg <= 1'b1;
                            if_rdata_reg  <= bus.mem_rdata;
                        end
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule
